mdu_iterative: RTL
==================

# mdu_iterative

Iterative 64-bit multiply/divide unit for the LEGv8 single-cycle datapath, covering MUL, SMULH, UMULH, SDIV and UDIV. It sits directly downstream of the register file: it takes the two read-port values (Rn, Rm) as operands. Its result and destination index feed the register-file write port (data_write, Rd, reg_wr) through the writeback mux. While busy, the control unit stalls the PC.

## Interface
- WIDTH, 64, operand/result width in bits; even, at least 8.
- clk  in  1  rising-edge clock shared with the register file.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code: 0 MUL, 1 SMULH, 2 UMULH, 3 SDIV, 4 UDIV; 5–7 invalid.
- operand_a  in  WIDTH  value from Reg_Rn (dividend / multiplicand).
- operand_b  in  WIDTH  value from Reg_Rm (divisor / multiplier).
- rd_in  in  5  destination register index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and rd_out are valid.
- reg_wr  out  1  equals done; drives the register-file write enable.
- result  out  WIDTH  final value; held until the next accepted start.
- rd_out  out  5  latched rd_in; held with result.

## Operation
- States are IDLE, CALC, FIX and DONE. Reset enters IDLE.
- **IDLE, start=1, valid op, not divide-by-zero:**
  - Latch op and rd_in.
  - Latch |operand_a| and |operand_b| for SMULH/SDIV; latch the raw values for the unsigned ops and MUL.
  - Latch the result sign: a[WIDTH-1]^b[WIDTH-1] for SMULH/SDIV; 0 otherwise.
  - Clear the 2·WIDTH accumulator and the counter, then go to CALC.
- **IDLE, start=1, op 3/4 with operand_b==0, or op 5–7:**
  - Set result=0, latch rd_in and go to DONE. This matches the ARMv8 divide-by-zero result.
- **CALC, multiply:** one radix-2 shift-add step per cycle, unsigned. The 2·WIDTH product is built in the accumulator.
- **CALC, divide:** one restoring shift-subtract step per cycle. Quotient and remainder stay in the accumulator halves.
- **CALC exit:** the counter runs 0..WIDTH-1. On the edge where the counter equals WIDTH-1, go to FIX.
- **FIX, result selection:**
  - If the sign flag is set, negate the magnitude (two's complement of the full 2·WIDTH product, or of the quotient).
  - MUL takes product[WIDTH-1:0]. SMULH/UMULH take product[2·WIDTH-1:WIDTH]. SDIV/UDIV take the quotient.
  - SDIV truncates toward zero. The remainder is discarded.
  - SDIV of the most-negative value by −1 gives the most-negative value (wraps, no trap). No special case is needed beyond correct negation.
  - Go to DONE.
- **DONE:** done=1 and reg_wr=1 for exactly one cycle, then go to IDLE.
- **start outside IDLE** is ignored. Operands are not re-sampled.
- **Reset values:** busy=0, done=0, reg_wr=0, result=0, rd_out=0, counter=0, state IDLE.
- **Reset mid-operation:** the operation is abandoned; no done pulse is produced.
- **rd_in==31:** the unit still pulses reg_wr. The register file discards the write (XZR).

## Timing
- Accepting edge = edge 0. Normal ops: state is CALC for edges 1..WIDTH, FIX after edge WIDTH, DONE after edge WIDTH+1.
  - done is high in the cycle after edge WIDTH+1: latency WIDTH+2 cycles (66 at the default).
- Shortcut ops (divide-by-zero, invalid op): DONE after edge 0, so done is high in the cycle after edge 0. Latency is 1 cycle.
- Minimum start-to-start spacing: latency+1 cycles (start can be accepted on the edge that leaves DONE for IDLE only if re-asserted in IDLE).
- busy rises in the cycle after the accepting edge and falls in the cycle after the DONE→IDLE edge.
- result, rd_out and done change only on clock edges (registered outputs). Operands may change freely after edge 0.

## Structure
- Shared package (mdu_pkg):
  - op encodings MDU_MUL=0, MDU_SMULH=1, MDU_UMULH=2, MDU_SDIV=3, MDU_UDIV=4.
  - state encodings IDLE/CALC/FIX/DONE.
  - default WIDTH.
- One sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode (mul/div). Output: next accumulator.
  - The top module owns the FSM, counter, sign handling and output registers.

## Test plan
- MUL, a=7, b=−3 → result 0xFFFF_FFFF_FFFF_FFEB; done exactly 66 cycles after start, one cycle wide; rd_out=rd_in=5.
- UMULH with a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. SMULH with the same operands (−1·−1) → 0.
- SDIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD (−3). UDIV 100/7 → 14. SDIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000.
- UDIV 5/0 → result 0, done one cycle after start, busy high only that cycle. op=6 → result 0, latency 1.
- start pulsed at cycle 10 of a running MUL with different operands → ignored; the original result is delivered at cycle 66.
- reset asserted mid-CALC (cycle 30), asynchronously between edges:
  - busy, done, result and rd_out read 0 immediately; no done pulse follows.
  - A fresh start after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on the op port
//   - FSM state encoding
//   - default operand/result width
package mdu_pkg;

   localparam int MDU_WIDTH = 64;

   localparam logic [2:0] MDU_MUL   = 3'd0;
   localparam logic [2:0] MDU_SMULH = 3'd1;
   localparam logic [2:0] MDU_UMULH = 3'd2;
   localparam logic [2:0] MDU_SDIV  = 3'd3;
   localparam logic [2:0] MDU_UDIV  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   i_acc     2*WIDTH accumulator (multiply: partial product;
//             divide: {remainder, quotient})
//   i_operand multiplicand (multiply) or divisor (divide), unsigned
//   i_bit     next multiplier / dividend bit, MSB first
//   i_mul     1 = shift-add multiply step, 0 = restoring divide step
//   o_acc     accumulator after this step
module mdu_step #(
   parameter int WIDTH = 64
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_operand,
   input  logic               i_bit,
   input  logic               i_mul,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [2*WIDTH-1:0] w_shl;
   logic [2*WIDTH-1:0] w_addend;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH:0]     w_diff;

   always_comb begin
      // Multiply is MSB-first: product = (product << 1) + (bit ? a : 0).
      w_shl    = {i_acc[2*WIDTH-2:0], 1'b0};
      w_addend = i_bit ? {{WIDTH{1'b0}}, i_operand} : '0;
      // Divide: remainder shifted with the next dividend bit. Since the
      // remainder is always below the divisor, a non-negative difference
      // never reaches bit WIDTH, so that bit is a clean borrow flag.
      w_trial  = {i_acc[2*WIDTH-1:WIDTH], i_bit};
      w_diff   = w_trial - {1'b0, i_operand};
      if (i_mul) begin
         o_acc = w_shl + w_addend;
      end else if (!w_diff[WIDTH]) begin
         o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
         o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative 64-bit MUL/SMULH/UMULH/SDIV/UDIV unit placed
// after the register file read ports; result goes to the write port.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_start, i_op         request and operation code (sampled in IDLE)
//   i_operand_a/_b        Rn / Rm values
//   i_rd_in               destination register index
//   o_busy                high in every state except IDLE
//   o_done, o_reg_wr      one-cycle completion pulse / write enable
//   o_result, o_rd_out    result and destination, held until next start
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add / shift-subtract step per cycle, WIDTH cycles
// FIX   | apply sign and select the result half
// DONE  | done/reg_wr pulse, return to IDLE
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic [4:0]       i_rd_in,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_reg_wr,
   output logic [WIDTH-1:0] o_result,
   output logic [4:0]       o_rd_out
);

   localparam int         CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   mdu_state_t         r_state;
   logic [2:0]         r_op;
   logic               r_sign;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_shift;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_result;
   logic [4:0]         r_rd;

   logic               w_in_div;
   logic               w_in_signed;
   logic               w_shortcut;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic               w_mul;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_quot_s;
   logic [WIDTH-1:0]   w_fix;

   assign w_in_div    = (i_op == MDU_SDIV) || (i_op == MDU_UDIV);
   assign w_in_signed = (i_op == MDU_SMULH) || (i_op == MDU_SDIV);
   assign w_shortcut  = (i_op > MDU_UDIV) || (w_in_div && (i_operand_b == '0));
   assign w_mag_a     = (w_in_signed && i_operand_a[WIDTH-1]) ? -i_operand_a : i_operand_a;
   assign w_mag_b     = (w_in_signed && i_operand_b[WIDTH-1]) ? -i_operand_b : i_operand_b;
   assign w_mul       = (r_op != MDU_SDIV) && (r_op != MDU_UDIV);

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_acc     (r_acc),
      .i_operand (r_opnd),
      .i_bit     (r_shift[WIDTH-1]),
      .i_mul     (w_mul),
      .o_acc     (w_acc_next)
   );

   // Magnitude 0x80..0 negates to itself, which gives the wrapping
   // SDIV(MIN, -1) = MIN behaviour without a special case.
   assign w_prod_s = r_sign ? -r_acc : r_acc;
   assign w_quot_s = r_sign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   always_comb begin
      w_fix = w_quot_s;
      case (r_op)
         MDU_MUL:              w_fix = w_prod_s[WIDTH-1:0];
         MDU_SMULH, MDU_UMULH: w_fix = w_prod_s[2*WIDTH-1:WIDTH];
         default:              w_fix = w_quot_s;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_op     <= MDU_MUL;
         r_sign   <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_opnd   <= '0;
         r_shift  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_rd     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_rd   <= i_rd_in;
                  r_busy <= 1'b1;
                  if (w_shortcut) begin
                     r_result <= '0;
                     r_done   <= 1'b1;
                     r_state  <= ST_DONE;
                  end else begin
                     r_op    <= i_op;
                     r_sign  <= w_in_signed & (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
                     // Step operand is the divisor / multiplicand; the
                     // shifted-out bits come from the dividend / multiplier.
                     r_opnd  <= w_in_div ? w_mag_b : w_mag_a;
                     r_shift <= w_in_div ? w_mag_a : w_mag_b;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_acc   <= w_acc_next;
               r_shift <= {r_shift[WIDTH-2:0], 1'b0};
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_result <= w_fix;
               r_done   <= 1'b1;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_reg_wr = r_done;
   assign o_result = r_result;
   assign o_rd_out = r_rd;

endmodule
